// File: rtl/slice_window.sv
// Sliding-window buffer: shifts multi-channel samples through DEPTH taps and
// presents the whole window every STRIDE accepts under valid/ready flow control.
module slice_window #(
    parameter int DWIDTH   = 8,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 3,
    parameter int STRIDE   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHANNELS*DWIDTH-1:0]         din,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DEPTH*CHANNELS*DWIDTH-1:0]   dout,
    output logic [$clog2(DEPTH+1)-1:0]         level
);
    localparam int W  = CHANNELS * DWIDTH;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [SW-1:0] SC_LAST    = SW'(STRIDE - 1);

    generate
        if (DEPTH < 2 || STRIDE < 1 || STRIDE > DEPTH) begin : g_bad_params
            $error("slice_window: DEPTH must be >= 2 and STRIDE in 1..DEPTH");
        end
    endgenerate

    logic [DEPTH*W-1:0] taps_q, taps_d;
    logic [LW-1:0]      level_q, level_d;
    logic [SW-1:0]      sc_q, sc_d, sc_next;
    logic               out_valid_q, out_valid_d;
    logic               accept;
    logic               emit;

    // A presented window blocks shifting until it is consumed.
    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        taps_d      = taps_q;
        level_d     = level_q;
        sc_d        = sc_q;
        out_valid_d = out_valid_q;
        emit        = 1'b0;
        sc_next     = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;

        if (flush) begin
            level_d     = '0;
            sc_d        = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                taps_d = {taps_q[(DEPTH-1)*W-1:0], din};
                if (level_q == LEVEL_FULL) begin
                    sc_d = sc_next;
                    emit = (sc_next == '0);
                end else begin
                    level_d = level_q + 1'b1;
                    emit    = (level_q == LEVEL_FULL - 1'b1);
                end
                if (emit) begin
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: taps are reset as well, because dout must read all-zero right after reset.
        if (!rst) begin
            taps_q      <= '0;
            level_q     <= '0;
            sc_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            level_q     <= level_d;
            sc_q        <= sc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = taps_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;

endmodule

// File: tb/tb_slice_window.sv
// Bench for slice_window: instance 0 (8-bit, 1 channel, stride 1) and instance 1
// (2x4-bit channels, stride 2), directed vectors plus randomized traffic vs a model.
module tb_slice_window;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       fl, iv, ordy, ir, ov;
    logic [1:0][7:0]  di;
    logic [1:0][23:0] dq;
    logic [1:0][1:0]  lv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slice_window #(.DWIDTH(8), .CHANNELS(1), .DEPTH(3), .STRIDE(1)) u_s1 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .din(di[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dq[0]), .level(lv[0])
    );

    slice_window #(.DWIDTH(4), .CHANNELS(2), .DEPTH(3), .STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .din(di[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dq[1]), .level(lv[1])
    );

    // Reference model: a 3-entry sample history and a count of accepts since clear.
    logic [7:0] m_taps [2][3];
    int         m_n    [2];
    bit         m_ov   [2];

    function automatic int stride_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic bit m_ready(input int i);
        return !fl[i] && (!m_ov[i] || ordy[i]);
    endfunction

    function automatic logic [23:0] m_window(input int i);
        return {m_taps[i][2], m_taps[i][1], m_taps[i][0]};
    endfunction

    function automatic logic [1:0] m_level(input int i);
        return (m_n[i] > 3) ? 2'd3 : 2'(m_n[i]);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit r;
            r = m_ready(i);
            if (!rst) begin
                for (int k = 0; k < 3; k++) m_taps[i][k] = '0;
                m_n[i]  = 0;
                m_ov[i] = 1'b0;
            end else if (fl[i]) begin
                m_n[i]  = 0;
                m_ov[i] = 1'b0;
            end else begin
                if (m_ov[i] && ordy[i]) m_ov[i] = 1'b0;
                if (iv[i] && r) begin
                    m_taps[i][2] = m_taps[i][1];
                    m_taps[i][1] = m_taps[i][0];
                    m_taps[i][0] = di[i];
                    m_n[i]++;
                    if (m_n[i] == 3 || (m_n[i] > 3 && (m_n[i] - 3) % stride_of(i) == 0))
                        m_ov[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check combinational ready, take the edge, check registered outputs.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(m_ready(i)));
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_ov[i]));
            check($sformatf("dout%0d", i), 32'(dq[i]), 32'(m_window(i)));
            check($sformatf("level%0d", i), 32'(lv[i]), 32'(m_level(i)));
        end
    endtask

    typedef struct {
        bit          f;
        bit          v;
        logic [7:0]  d;
        bit          r;
        bit          x_rdy;
        bit          x_ov;
        logic [23:0] x_dout;
        logic [1:0]  x_lvl;
    } vec_t;

    function automatic vec_t mk(input bit f, input bit v, input logic [7:0] d, input bit r,
                                input bit x_rdy, input bit x_ov, input logic [23:0] x_dout,
                                input logic [1:0] x_lvl);
        vec_t t;
        t.f = f; t.v = v; t.d = d; t.r = r;
        t.x_rdy = x_rdy; t.x_ov = x_ov; t.x_dout = x_dout; t.x_lvl = x_lvl;
        return t;
    endfunction

    vec_t tbl [19];

    initial begin
        // Fill, streaming, back-pressure, then flush on the stride-1 instance.
        tbl[0]  = mk(0, 1, 8'h11, 1, 1, 0, 24'h000011, 2'd1);
        tbl[1]  = mk(0, 1, 8'h22, 1, 1, 0, 24'h001122, 2'd2);
        tbl[2]  = mk(0, 1, 8'h33, 0, 1, 1, 24'h112233, 2'd3);
        tbl[3]  = mk(0, 1, 8'h44, 1, 1, 1, 24'h223344, 2'd3);
        tbl[4]  = mk(0, 1, 8'h55, 1, 1, 1, 24'h334455, 2'd3);
        tbl[5]  = mk(0, 1, 8'h66, 0, 0, 1, 24'h334455, 2'd3);
        tbl[6]  = mk(0, 1, 8'h66, 0, 0, 1, 24'h334455, 2'd3);
        tbl[7]  = mk(0, 1, 8'h66, 0, 0, 1, 24'h334455, 2'd3);
        tbl[8]  = mk(0, 1, 8'h66, 0, 0, 1, 24'h334455, 2'd3);
        tbl[9]  = mk(0, 1, 8'h66, 1, 1, 1, 24'h445566, 2'd3);
        tbl[10] = mk(0, 0, 8'h00, 1, 1, 0, 24'h445566, 2'd3);
        tbl[11] = mk(0, 1, 8'h77, 1, 1, 1, 24'h556677, 2'd3);
        tbl[12] = mk(0, 1, 8'h88, 1, 1, 1, 24'h667788, 2'd3);
        tbl[13] = mk(1, 1, 8'h99, 0, 0, 0, 24'h667788, 2'd0);
        tbl[14] = mk(0, 1, 8'h99, 0, 1, 0, 24'h778899, 2'd1);
        tbl[15] = mk(0, 1, 8'hAA, 0, 1, 0, 24'h8899AA, 2'd2);
        tbl[16] = mk(0, 1, 8'hBB, 0, 1, 1, 24'h99AABB, 2'd3);
        tbl[17] = mk(0, 1, 8'hCC, 0, 0, 1, 24'h99AABB, 2'd3);
        tbl[18] = mk(0, 0, 8'h00, 1, 1, 0, 24'h99AABB, 2'd3);

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) m_taps[i][k] = '0;
            m_n[i]  = 0;
            m_ov[i] = 1'b0;
        end
        rst = 1'b0; fl = '0; iv = '0; ordy = '0; di = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ov%0d", i), 32'(ov[i]), 32'd0);
            check($sformatf("reset_dout%0d", i), 32'(dq[i]), 32'd0);
            check($sformatf("reset_level%0d", i), 32'(lv[i]), 32'd0);
        end
        rst = 1'b1;

        for (int n = 0; n < 19; n++) begin
            fl[0] = tbl[n].f; iv[0] = tbl[n].v; di[0] = tbl[n].d; ordy[0] = tbl[n].r;
            #1;
            check($sformatf("vec%0d_in_ready", n), 32'(ir[0]), 32'(tbl[n].x_rdy));
            tick();
            check($sformatf("vec%0d_out_valid", n), 32'(ov[0]), 32'(tbl[n].x_ov));
            check($sformatf("vec%0d_dout", n), 32'(dq[0]), 32'(tbl[n].x_dout));
            check($sformatf("vec%0d_level", n), 32'(lv[0]), 32'(tbl[n].x_lvl));
        end
        fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;

        // Stride 2: windows only after samples 3, 5 and 7.
        for (int k = 1; k <= 7; k++) begin
            iv[1] = 1'b1; di[1] = 8'(k); ordy[1] = 1'b1;
            tick();
            check($sformatf("stride_k%0d_ov", k), 32'(ov[1]), 32'(k == 3 || k == 5 || k == 7));
            if (k == 3 || k == 5 || k == 7)
                check($sformatf("stride_k%0d_tap0", k), 32'(dq[1][7:0]), 32'(k));
        end
        iv[1] = 1'b0; fl[1] = 1'b1;
        tick();
        check("flush_level", 32'(lv[1]), 32'd0);
        check("flush_ov", 32'(ov[1]), 32'd0);
        fl[1] = 1'b0; ordy[1] = 1'b0;

        // Two channels: channel 1 in the high nibble of each tap.
        iv[1] = 1'b1;
        di[1] = 8'hA1; tick();
        di[1] = 8'hB2; tick();
        check("mc_no_early_window", 32'(ov[1]), 32'd0);
        di[1] = 8'hC3; tick();
        iv[1] = 1'b0;
        check("mc_window", 32'(dq[1]), 32'hA1B2C3);
        check("mc_ch0_tap0", 32'(dq[1][3:0]), 32'h3);
        check("mc_ch1_tap0", 32'(dq[1][7:4]), 32'hC);
        check("mc_ch1_tap2", 32'(dq[1][23:20]), 32'hA);
        check("mc_ov", 32'(ov[1]), 32'd1);
        check("mc_level", 32'(lv[1]), 32'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mc_rst_dout", 32'(dq[1]), 32'd0);
        check("mc_rst_ov", 32'(ov[1]), 32'd0);
        check("mc_rst_level", 32'(lv[1]), 32'd0);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < 2; i++) begin
                fl[i]   = ($urandom_range(0, 24) == 0);
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 2) != 0);
                di[i]   = 8'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_window.md
# slice_window

Parametrised sliding-window buffer, successor to the single-lane slice shift register in the pixel datapath. It accepts a stream of multi-channel samples over a valid/ready handshake and shifts them through a DEPTH-tap window. It presents the full window in parallel once DEPTH samples are held, emitting one window every STRIDE accepted samples with back-pressure. It sits between the frame/line source and the convolution/filter stages.

## Interface

- `DWIDTH`, 8, bits per channel sample
- `CHANNELS`, 1, parallel channels sharing one handshake
- `DEPTH`, 3, window taps (≥2)
- `STRIDE`, 1, accepted samples between emitted windows after first fill (1..DEPTH)
- `clk` input 1: single clock; all logic on posedge
- `rst` input 1: reset, synchronous, active-low
- `flush` input 1: synchronous clear of window occupancy and stride state
- `in_valid` input 1: `din` holds a sample
- `in_ready` output 1: block accepts a sample this cycle
- `din` input CHANNELS*DWIDTH: sample; channel c at bits [DWIDTH*(c+1)-1 : DWIDTH*c]
- `out_valid` output 1: `dout` holds a complete window
- `out_ready` input 1: downstream consumes the window
- `dout` output DEPTH*CHANNELS*DWIDTH: tap k at bits [W*(k+1)-1 : W*k], W = CHANNELS*DWIDTH; tap 0 is the newest sample
- `level` output clog2(DEPTH+1): valid taps held, saturating at DEPTH

## Operation

- Accept = `in_valid & in_ready`. On accept: tap 0 <= `din`, tap k <= tap k-1 for k = 1..DEPTH-1, and the oldest tap is discarded.
- `in_ready` = `~flush & (~out_valid | out_ready)`. The window never shifts while a presented window is unconsumed.
- `level` increments on accept and saturates at DEPTH.
- Stride counter `sc` (0..STRIDE-1):
  - Held at 0 until `level` reaches DEPTH.
  - After the fill, each accept sets `sc <= (sc+1) mod STRIDE`.
- Emit condition, evaluated on accept:
  - The accept that brings `level` to DEPTH always emits.
  - Subsequent accepts emit when the new `sc` is 0.
- `out_valid` update:
  - Set on an emitting accept.
  - Cleared on `out_valid & out_ready` with no emitting accept in the same cycle.
  - Stays 1 across a consume-and-emit in the same cycle.
- `flush`:
  - Sets `level` to 0, `sc` to 0 and `out_valid` to 0.
  - Tap data is left unchanged; `in_ready` is 0 during flush, so no sample is lost silently.
- Reset (`rst` = 0 at posedge): all taps 0, `level` 0, `sc` 0, `out_valid` 0. Reset overrides flush and accept.
- Widths: no arithmetic on data; `sc` and `level` wrap and saturate exactly as stated. Illegal STRIDE is rejected at elaboration.

## Timing

- Every register updates on the posedge of `clk`. `in_ready` is combinational from `flush`, `out_valid` and `out_ready`. `dout`, `out_valid` and `level` are registered.
- Latency: `out_valid` rises the cycle after the emitting accept edge, and `dout` is valid in that same cycle.
- With STRIDE=1, `out_ready` held 1 and `in_valid` held 1, throughput after fill is one window per cycle.
- With STRIDE=S, windows are S accepts apart after the first.
- `dout` is stable while `out_valid & ~out_ready`.
- After reset or flush, the first window needs exactly DEPTH accepts.
- Reset mid-stream: the next cycle shows `out_valid` 0, `level` 0 and `dout` all zero.

## Test plan

- Reset then fill: DEPTH=3, CHANNELS=1, feed 0x11, 0x22, 0x33 back-to-back → `out_valid` 1 on the cycle after the third accept, `dout` = 0x112233 (tap0 = 0x33), `level` = 3.
- Streaming STRIDE=1: continue with 0x44, 0x55 and `out_ready` held 1 → consecutive windows 0x223344 then 0x334455, one per cycle, `in_ready` constantly 1.
- Back-pressure: hold `out_ready` 0 with the window valid for 4 cycles while `in_valid` is 1 → `in_ready` 0, `dout` unchanged, `level` unchanged; release → the pending sample is accepted in the same cycle the window is consumed.
- Stride: STRIDE=2, feed 1..7 → windows emitted after samples 3, 5 and 7 only (tap0 = 3, 5, 7).
- Flush mid-stream: flush after 2 samples, then feed 3 samples → no window before the third post-flush accept, `in_ready` 0 during the flush cycle, `level` 0 the cycle after.
- Multi-channel with reset: CHANNELS=2, DWIDTH=4, feed 0xA1, 0xB2, 0xC3, assert `rst` = 0 one cycle with `out_valid` high → channel ordering in `dout` is correct; after reset `dout` = 0, `out_valid` 0, `level` 0.
